// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator for XLEN 32/64.
// Decodes all immediate formats into a 2-entry valid/ready output buffer.
module imm_gen_pipe #(
  parameter int XLEN       = 64,
  parameter bit ULOAD_ZEXT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_REG32 = 7'b0111011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
  } ent_t;

  logic [6:0] op;
  logic [2:0] f3;
  assign op = instr[6:0];
  assign f3 = instr[14:12];

  // All formats are built 64 bits wide and truncated, so XLEN=32
  // simply drops the upper sign-extension bits.
  logic [63:0] i_sx, i_zx, s_sx, b_sx, u_sx, j_sx, sh_zx;

  assign i_sx = {{52{instr[31]}}, instr[31:20]};
  assign i_zx = {52'b0, instr[31:20]};
  assign s_sx = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_sx = {{51{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
  assign u_sx = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign j_sx = {{43{instr[31]}}, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
  assign sh_zx = (XLEN == 64 && op == OP_IMM)
               ? {58'b0, instr[25:20]}
               : {59'b0, instr[24:20]};

  logic is_opimm, is_sh, is_opi, is_load, is_jalr, is_st;
  logic is_br, is_u, is_jal, is_noimm, is_uload;

  assign is_opimm = (op == OP_IMM) || (op == OP_IMM32);
  assign is_sh    = is_opimm && (f3 == 3'b001 || f3 == 3'b101);
  assign is_opi   = is_opimm && !is_sh;
  assign is_load  = (op == OP_LOAD);
  assign is_jalr  = (op == OP_JALR);
  assign is_st    = (op == OP_STORE);
  assign is_br    = (op == OP_BR);
  assign is_u     = (op == OP_LUI) || (op == OP_AUIPC);
  assign is_jal   = (op == OP_JAL);
  assign is_noimm = (op == OP_REG) || (op == OP_REG32) ||
                    (op == OP_SYS) || (op == OP_FENCE);
  assign is_uload = (f3 == 3'b100) || (f3 == 3'b101) ||
                    (f3 == 3'b110);

  logic [63:0] wide;
  ent_t        dec;

  always_comb begin
    wide    = '0;
    dec     = '0;
    unique case (1'b1)
      is_sh: begin
        wide    = sh_zx;
        dec.typ = T_SHAMT;
      end
      is_opi: begin
        wide    = i_sx;
        dec.typ = T_I;
      end
      is_load: begin
        wide    = (ULOAD_ZEXT && is_uload) ? i_zx : i_sx;
        dec.typ = T_I;
      end
      is_jalr: begin
        if (f3 == 3'b000) begin
          wide    = i_sx;
          dec.typ = T_I;
        end else begin
          dec.ill = 1'b1;
        end
      end
      is_st: begin
        wide    = s_sx;
        dec.typ = T_S;
      end
      is_br: begin
        wide    = b_sx;
        dec.typ = T_B;
      end
      is_u: begin
        wide    = u_sx;
        dec.typ = T_U;
      end
      is_jal: begin
        wide    = j_sx;
        dec.typ = T_J;
      end
      is_noimm: begin
        dec.typ = T_NONE;
      end
      default: begin
        dec.ill = 1'b1;
      end
    endcase
    dec.imm = wide[XLEN-1:0];
  end

  ent_t       head_q, tail_q;
  logic [1:0] cnt_q;
  logic       push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head register stays untouched when drained, so outputs keep
  // their last values while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (push) begin
            head_q <= dec;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= dec;
          end else if (push) begin
            tail_q <= dec;
            cnt_q  <= 2'd2;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            cnt_q  <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  assign imm      = head_q.imm;
  assign imm_type = head_q.typ;
  assign illegal  = head_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN64/sext and XLEN32/zext
// instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        ir_a, ov_a, il_a;
  logic [63:0] imm_a;
  logic [2:0]  ty_a;
  logic        ir_b, ov_b, il_b;
  logic [31:0] imm_b;
  logic [2:0]  ty_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] e64;
    logic [31:0] e32;
    logic [2:0]  t;
    logic        il;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .ULOAD_ZEXT(1'b0)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_a), .instr(instr),
    .out_valid(ov_a), .out_ready(out_ready),
    .imm(imm_a), .imm_type(ty_a), .illegal(il_a)
  );

  imm_gen_pipe #(.XLEN(32), .ULOAD_ZEXT(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_b), .instr(instr),
    .out_valid(ov_b), .out_ready(out_ready),
    .imm(imm_b), .imm_type(ty_b), .illegal(il_b)
  );

  // Scoreboard: pop and compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && !flush && ov_a && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: unexpected output imm=%h type=%0d",
                 imm_a, ty_a);
      end else begin
        e = sb.pop_front();
        if ({imm_a, ty_a, il_a} !== {e.e64, e.t, e.il}) begin
          failures++;
          $display("FAIL out64: got %h/%0d/%b want %h/%0d/%b",
                   imm_a, ty_a, il_a, e.e64, e.t, e.il);
        end
        checks++;
        if ({ov_b, imm_b, ty_b, il_b} !== {1'b1, e.e32, e.t, e.il}) begin
          failures++;
          $display("FAIL out32: got %b/%h/%0d/%b want 1/%h/%0d/%b",
                   ov_b, imm_b, ty_b, il_b, e.e32, e.t, e.il);
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic [63:0] e64,
                      input logic [31:0] e32, input logic [2:0] t,
                      input logic il);
    int n = 0;
    exp_t x;
    x.e64 = e64; x.e32 = e32; x.t = t; x.il = il;
    instr    = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!ir_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir_a) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%b want 1 instr=%h", ir_a, w);
    end else begin
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; instr = '0;
    #12;
    checks++;
    if ({ov_a, ir_a, imm_a, ty_a, il_a} !== {1'b0, 1'b1, 64'h0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset64: ov=%b ir=%b imm=%h ty=%0d il=%b want 0 1 0 0 0",
               ov_a, ir_a, imm_a, ty_a, il_a);
    end
    checks++;
    if ({ov_b, ir_b, imm_b, ty_b, il_b} !== {1'b0, 1'b1, 32'h0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset32: ov=%b ir=%b imm=%h want 0 1 0", ov_b, ir_b, imm_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
    checks++;
    if ({ov_a, imm_a, ty_a} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1}) begin
      failures++;
      $display("FAIL latency: ov=%b imm=%h ty=%0d want 1 all-ones 1",
               ov_a, imm_a, ty_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ov_a, imm_a, ty_a} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1}) begin
      failures++;
      $display("FAIL empty_hold: ov=%b imm=%h ty=%0d want 0 all-ones 1",
               ov_a, imm_a, ty_a);
    end
  endtask

  task automatic test_formats();
    out_ready = 1'b1;
    send(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd3, 1'b0);
    send(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4, 1'b0);
    send(32'h12345017, 64'h0000_0000_1234_5000, 32'h1234_5000, 3'd4, 1'b0);
    send(32'h03F09093, 64'd63, 32'd31, 3'd6, 1'b0);
    send(32'h43F0D093, 64'd63, 32'd31, 3'd6, 1'b0);
    send(32'h43F0D09B, 64'd31, 32'd31, 3'd6, 1'b0);
    send(32'h8000009B, 64'hFFFF_FFFF_FFFF_F800, 32'hFFFF_F800, 3'd1, 1'b0);
    send(32'hFFF04083, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0FFF, 3'd1, 1'b0);
    send(32'hFFF00083, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
    send(32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd2, 1'b0);
    send(32'hFFFFF06F, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFE, 3'd5, 1'b0);
    send(32'h0040006F, 64'd4, 32'd4, 3'd5, 1'b0);
    send(32'hFFC08067, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd1, 1'b0);
    send(32'h00001067, 64'd0, 32'd0, 3'd0, 1'b1);
    send(32'h00000000, 64'd0, 32'd0, 3'd0, 1'b1);
    send(32'h002081B3, 64'd0, 32'd0, 3'd0, 1'b0);
    send(32'h0000000F, 64'd0, 32'd0, 3'd0, 1'b0);
    send(32'h00000073, 64'd0, 32'd0, 3'd0, 1'b0);
    send(32'h0000007F, 64'd0, 32'd0, 3'd0, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    int n = 0;
    exp_t c;
    c.e64 = 64'hFFFF_FFFF_8000_0000; c.e32 = 32'h8000_0000;
    c.t = 3'd4; c.il = 1'b0;
    out_ready = 1'b0;
    send(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
    send(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd3, 1'b0);
    instr    = 32'h800000B7;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({ir_a, ov_a, imm_a, ty_a} !== {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1}) begin
        failures++;
        $display("FAIL full_hold: ir=%b ov=%b imm=%h ty=%0d want 0 1 all-ones 1",
                 ir_a, ov_a, imm_a, ty_a);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    while (!ir_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ir_a) begin
      failures++;
      $display("FAIL c_accept: in_ready=%b want 1", ir_a);
    end else begin
      sb.push_back(c);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t b;
    b.e64 = 64'hFFFF_FFFF_FFFF_FFF8; b.e32 = 32'hFFFF_FFF8;
    b.t = 3'd2; b.il = 1'b0;
    out_ready = 1'b0;
    send(32'h0040006F, 64'd4, 32'd4, 3'd5, 1'b0);
    out_ready = 1'b1;
    instr     = 32'hFE20AC23;
    in_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (ir_a !== 1'b1) begin
      failures++;
      $display("FAIL pushpop_ready: in_ready=%b want 1", ir_a);
    end else begin
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({ov_a, ir_a, imm_a, ty_a} !== {1'b1, 1'b1, b.e64, 3'd2}) begin
      failures++;
      $display("FAIL pushpop_cnt1: ov=%b ir=%b imm=%h ty=%0d want 1 1 %h 2",
               ov_a, ir_a, imm_a, ty_a, b.e64);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ov_a !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_drain: ov=%b want 0", ov_a);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
    send(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      instr    = 32'h12345017;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      checks++;
      if ({ov_a, ir_a, ov_b, ir_b} !== 4'b0101) begin
        failures++;
        $display("FAIL flush%0d: ov=%b ir=%b ov32=%b ir32=%b want 0 1 0 1",
                 k, ov_a, ir_a, ov_b, ir_b);
      end
      if (k == 0) begin
        send(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
      end
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov_a !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop: ov=%b want 0", ov_a);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd3, 1'b0);
    send(32'h03F09093, 64'd63, 32'd31, 3'd6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({ov_a, ir_a, imm_a, ty_a, il_a} !== {1'b0, 1'b1, 64'h0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_rst: ov=%b ir=%b imm=%h ty=%0d il=%b want 0 1 0 0 0",
               ov_a, ir_a, imm_a, ty_a, il_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({ov_a, ir_a} !== 2'b01) begin
      failures++;
      $display("FAIL post_rst: ov=%b ir=%b want 0 1", ov_a, ir_a);
    end
    out_ready = 1'b1;
    send(32'h00000000, 64'd0, 32'd0, 3'd0, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_formats();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined RISC-V immediate generator: the successor to the combinational sign-extension block.
- Decodes every immediate format (I, S, B, U, J, shift-amount) for XLEN 32 or 64.
- Registers results into a 2-entry output buffer with valid/ready handshake, so it can sit between the fetch/IR stage and the execute stage with back-pressure and flush.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- ULOAD_ZEXT, 0, 1 = zero-extend offsets of lbu/lhu/lwu (legacy datapath compatibility); 0 = architecturally correct sign extension.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of buffered entries.
- in_valid  in  1  instr is valid.
- in_ready  out  1  block can accept instr this cycle.
- instr  in  32  raw instruction word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head entry this cycle.
- imm  out  XLEN  extended immediate of head entry.
- imm_type  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- illegal  out  1  head entry opcode unrecognised.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Buffer count = 0, out_valid = 0, in_ready = 1.
  - imm = 0, imm_type = 0, illegal = 0.
  - Reset mid-operation discards all entries.
- Decode is combinational on instr; the result is written into the buffer on accept (in_valid && in_ready).
- Opcode map (instr[6:0]):
  - 0010011 / 0011011 (OP-IMM / OP-IMM-32):
    - funct3 001 or 101: SHAMT, imm = zero-extended instr[25:20] for XLEN 64 or instr[24:20] for XLEN 32, or for OP-IMM-32. The funct7 bit 30 is excluded.
    - Otherwise: I, imm = sext(instr[31:20]).
  - 0000011 (LOAD): I, sext(instr[31:20]). When ULOAD_ZEXT=1 and funct3 is 100/101/110, zero-extended instead.
  - 1100111 (JALR, funct3 000): I. Other funct3 values: NONE, illegal=1.
  - 0100011 (STORE): S, sext({instr[31:25], instr[11:7]}).
  - 1100011 (BRANCH): B, sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). Bit 0 is always 0.
  - 0110111 / 0010111 (LUI / AUIPC): U, sext({instr[31:12], 12'b0}) to XLEN.
  - 1101111 (JAL): J, sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011 / 0111011 / 1110011 / 0001111: NONE, imm 0, illegal 0.
  - Any other opcode: NONE, imm 0, illegal 1. The entry is still buffered so ordering is preserved.
- Buffer: 2-entry FIFO, head drives the outputs.
  - in_ready = (count < 2), derived from registered count only (no combinational path from out_ready).
  - Latency: accept in cycle N → out_valid high in N+1 if the buffer was empty.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - count 2: in_ready = 0; in_valid ignored.
  - Output fields hold stable while out_valid && !out_ready.
  - When the buffer is empty, out_valid = 0 and imm/imm_type/illegal hold their last values.
- Flush: next cycle count = 0 and out_valid = 0. Flush has priority over simultaneous push and pop; an instruction presented with flush is dropped.
- XLEN=32: upper sign-extension logic absent; LUI 0x80000 yields 0x8000_0000.

Test Plan:
- Basic I-type: XLEN=64, push 0xFFF00093 (addi x1,x0,-1) into empty buffer, out_ready=1 → next cycle out_valid=1, imm=0xFFFF_FFFF_FFFF_FFFF, imm_type=1, illegal=0.
- Branch and LUI: push 0xFE000EE3 (beq -4) → imm=0xFFFF_FFFF_FFFF_FFFC, type 3. Then push 0x800000B7 (lui 0x80000) → imm=0xFFFF_FFFF_8000_0000, type 4. With XLEN=32 → 0x8000_0000.
- Shift and unsigned loads:
  - Push 0x03F09093 (slli 63) → imm=63, type 6.
  - Push 0x43F0D093 (srai 63) → imm=63, not 0x43F.
  - Push 0xFFF04083 (lbu -1) → all ones with ULOAD_ZEXT=0; 0x0000_0000_0000_0FFF with ULOAD_ZEXT=1.
- Back-pressure: out_ready=0, present A, B, C back-to-back → A and B accepted, in_ready=0 while C is held. Raise out_ready → A, B, C emerge in order, no duplicates. Also push+pop same cycle at count 1 → count stays 1.
- Illegal/no-immediate:
  - Push 0x00000000 → type 0, illegal=1, buffered in order.
  - Push 0x002081B3 (add) → type 0, illegal=0.
  - Push 0x00001067 (jalr funct3 001) → illegal=1.
- Flush and reset: fill 2 entries, assert flush with in_valid=1 → next cycle out_valid=0, count 0, new instr dropped. Assert rst_n low asynchronously mid-stream (between edges) → outputs zero immediately, in_ready=1 after release.
